// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant between the CPU LSU (port 0)
// and the DMA (port 1), with a per-transaction READY timeout and grant counters.
module mem_arbiter #(
   parameter int ADDR_W  = 18,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_p0_ADDR,
   input  logic [31:0]       i_p0_WDATA,
   input  logic [3:0]        i_p0_BMASK,
   input  logic              i_p0_WREN,
   input  logic              i_p0_VALID,
   output logic              o_p0_READY,
   output logic [31:0]       o_p0_RDATA,
   input  logic [ADDR_W-1:0] i_p1_ADDR,
   input  logic [31:0]       i_p1_WDATA,
   input  logic [3:0]        i_p1_BMASK,
   input  logic              i_p1_WREN,
   input  logic              i_p1_VALID,
   output logic              o_p1_READY,
   output logic [31:0]       o_p1_RDATA,
   output logic [ADDR_W-1:0] o_mem_ADDR,
   output logic [31:0]       o_mem_WDATA,
   output logic [3:0]        o_mem_BMASK,
   output logic              o_mem_WREN,
   output logic              o_mem_VALID,
   input  logic [31:0]       i_mem_RDATA,
   input  logic              i_mem_READY,
   output logic              o_timeout,
   output logic [15:0]       o_grant_cnt0,
   output logic [15:0]       o_grant_cnt1
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   state_t      state_reg, state_next;
   logic        prio_reg, prio_next;
   logic [15:0] wait_reg, wait_next;
   logic [15:0] grant_cnt0_reg, grant_cnt0_next;
   logic [15:0] grant_cnt1_reg, grant_cnt1_next;
   logic [1:0]  ready_vec;
   logic [1:0]  done_vec;
   logic        busy_sel;
   logic        sel_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg      <= IDLE;
         prio_reg       <= 1'b0;
         wait_reg       <= 16'd0;
         grant_cnt0_reg <= 16'd0;
         grant_cnt1_reg <= 16'd0;
      end else begin
         state_reg      <= state_next;
         prio_reg       <= prio_next;
         wait_reg       <= wait_next;
         grant_cnt0_reg <= grant_cnt0_next;
         grant_cnt1_reg <= grant_cnt1_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      prio_next   = prio_reg;
      wait_next   = wait_reg;
      ready_vec   = 2'b00;
      done_vec    = 2'b00;
      o_timeout   = 1'b0;
      o_mem_VALID = 1'b0;
      // IDLE falls through to port 0 for the address/data mux
      busy_sel    = (state_reg == BUSY1);
      sel_valid   = busy_sel ? i_p1_VALID : i_p0_VALID;
      o_mem_ADDR  = busy_sel ? i_p1_ADDR  : i_p0_ADDR;
      o_mem_WDATA = busy_sel ? i_p1_WDATA : i_p0_WDATA;
      o_mem_BMASK = busy_sel ? i_p1_BMASK : i_p0_BMASK;
      o_mem_WREN  = busy_sel ? i_p1_WREN  : i_p0_WREN;

      case (state_reg)
         IDLE: begin
            wait_next = 16'd0;
            if (i_p0_VALID && i_p1_VALID) begin
               state_next = prio_reg ? BUSY1 : BUSY0;
            end else if (i_p0_VALID) begin
               state_next = BUSY0;
            end else if (i_p1_VALID) begin
               state_next = BUSY1;
            end
         end
         BUSY0, BUSY1: begin
            o_mem_VALID = sel_valid;
            // A requester withdrawing mid-transaction is dropped silently
            if (!sel_valid) begin
               state_next = IDLE;
            end else if (i_mem_READY) begin
               ready_vec[busy_sel] = 1'b1;
               done_vec[busy_sel]  = 1'b1;
               prio_next           = ~busy_sel;
               state_next          = IDLE;
            end else if (wait_reg == TIMEOUT_W) begin
               ready_vec[busy_sel] = 1'b1;
               o_timeout           = 1'b1;
               prio_next           = ~busy_sel;
               state_next          = IDLE;
            end else begin
               wait_next = wait_reg + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign grant_cnt0_next = (done_vec[0] && (grant_cnt0_reg != 16'hFFFF)) ?
                            grant_cnt0_reg + 16'd1 : grant_cnt0_reg;
   assign grant_cnt1_next = (done_vec[1] && (grant_cnt1_reg != 16'hFFFF)) ?
                            grant_cnt1_reg + 16'd1 : grant_cnt1_reg;

   assign o_p0_READY   = ready_vec[0];
   assign o_p1_READY   = ready_vec[1];
   assign o_p0_RDATA   = i_mem_RDATA;
   assign o_p1_RDATA   = i_mem_RDATA;
   assign o_grant_cnt0 = grant_cnt0_reg;
   assign o_grant_cnt1 = grant_cnt1_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inputs driven and
// outputs sampled just after the falling clock edge.
module tb_mem_arbiter;

   localparam int ADDR_W  = 18;
   localparam int TIMEOUT = 4;

   logic              i_clk;
   logic              i_rst_n;
   logic [ADDR_W-1:0] i_p0_ADDR, i_p1_ADDR;
   logic [31:0]       i_p0_WDATA, i_p1_WDATA;
   logic [3:0]        i_p0_BMASK, i_p1_BMASK;
   logic              i_p0_WREN, i_p1_WREN;
   logic              i_p0_VALID, i_p1_VALID;
   logic              o_p0_READY, o_p1_READY;
   logic [31:0]       o_p0_RDATA, o_p1_RDATA;
   logic [ADDR_W-1:0] o_mem_ADDR;
   logic [31:0]       o_mem_WDATA;
   logic [3:0]        o_mem_BMASK;
   logic              o_mem_WREN, o_mem_VALID;
   logic [31:0]       i_mem_RDATA;
   logic              i_mem_READY;
   logic              o_timeout;
   logic [15:0]       o_grant_cnt0, o_grant_cnt1;

   int checks = 0;
   int passed = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_p0_ADDR(i_p0_ADDR), .i_p0_WDATA(i_p0_WDATA), .i_p0_BMASK(i_p0_BMASK),
      .i_p0_WREN(i_p0_WREN), .i_p0_VALID(i_p0_VALID),
      .o_p0_READY(o_p0_READY), .o_p0_RDATA(o_p0_RDATA),
      .i_p1_ADDR(i_p1_ADDR), .i_p1_WDATA(i_p1_WDATA), .i_p1_BMASK(i_p1_BMASK),
      .i_p1_WREN(i_p1_WREN), .i_p1_VALID(i_p1_VALID),
      .o_p1_READY(o_p1_READY), .o_p1_RDATA(o_p1_RDATA),
      .o_mem_ADDR(o_mem_ADDR), .o_mem_WDATA(o_mem_WDATA), .o_mem_BMASK(o_mem_BMASK),
      .o_mem_WREN(o_mem_WREN), .o_mem_VALID(o_mem_VALID),
      .i_mem_RDATA(i_mem_RDATA), .i_mem_READY(i_mem_READY),
      .o_timeout(o_timeout),
      .o_grant_cnt0(o_grant_cnt0), .o_grant_cnt1(o_grant_cnt1)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      i_p0_ADDR = '0; i_p0_WDATA = '0; i_p0_BMASK = '0; i_p0_WREN = 1'b0; i_p0_VALID = 1'b0;
      i_p1_ADDR = '0; i_p1_WDATA = '0; i_p1_BMASK = '0; i_p1_WREN = 1'b0; i_p1_VALID = 1'b0;
      i_mem_RDATA = '0; i_mem_READY = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      idle_inputs();
      i_p0_VALID = 1'b1;
      i_mem_READY = 1'b1;
      repeat (2) @(negedge i_clk);
      #1;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL reset_mem_valid got=%b exp=0", o_mem_VALID); else passed++;
      checks++; if (o_p0_READY !== 1'b0) $display("FAIL reset_p0_ready got=%b exp=0", o_p0_READY); else passed++;
      checks++; if (o_p1_READY !== 1'b0) $display("FAIL reset_p1_ready got=%b exp=0", o_p1_READY); else passed++;
      checks++; if (o_timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", o_timeout); else passed++;
      checks++; if (o_grant_cnt0 !== 16'd0) $display("FAIL reset_cnt0 got=%h exp=0000", o_grant_cnt0); else passed++;
      checks++; if (o_grant_cnt1 !== 16'd0) $display("FAIL reset_cnt1 got=%h exp=0000", o_grant_cnt1); else passed++;
      i_p0_VALID = 1'b0;
      i_mem_READY = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      $display("txn reset: held low two cycles, released");
   endtask

   task automatic test_single_read();
      @(negedge i_clk);
      i_p0_ADDR = 18'h00010; i_p0_WREN = 1'b0; i_p0_VALID = 1'b1;
      #1;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL read_arb_cycle got=%b exp=0", o_mem_VALID); else passed++;
      @(negedge i_clk); #1;
      checks++; if (o_mem_VALID !== 1'b1) $display("FAIL read_mem_valid got=%b exp=1", o_mem_VALID); else passed++;
      checks++; if (o_mem_ADDR !== 18'h00010) $display("FAIL read_mem_addr got=%h exp=00010", o_mem_ADDR); else passed++;
      checks++; if (o_p0_READY !== 1'b0) $display("FAIL read_early_ready got=%b exp=0", o_p0_READY); else passed++;
      @(negedge i_clk);
      i_mem_READY = 1'b1; i_mem_RDATA = 32'hCAFEF00D;
      #1;
      checks++; if (o_p0_READY !== 1'b1) $display("FAIL read_p0_ready got=%b exp=1", o_p0_READY); else passed++;
      checks++; if (o_p0_RDATA !== 32'hCAFEF00D) $display("FAIL read_p0_rdata got=%h exp=cafef00d", o_p0_RDATA); else passed++;
      checks++; if (o_p1_RDATA !== 32'hCAFEF00D) $display("FAIL read_p1_rdata got=%h exp=cafef00d", o_p1_RDATA); else passed++;
      checks++; if (o_p1_READY !== 1'b0) $display("FAIL read_p1_ready got=%b exp=0", o_p1_READY); else passed++;
      // back in IDLE: VALID still high and memory READY high, yet nothing issued
      @(negedge i_clk); #1;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL read_idle_gap got=%b exp=0", o_mem_VALID); else passed++;
      checks++; if (o_p0_READY !== 1'b0) $display("FAIL read_idle_ready got=%b exp=0", o_p0_READY); else passed++;
      checks++; if (o_grant_cnt0 !== 16'd1) $display("FAIL read_cnt0 got=%h exp=0001", o_grant_cnt0); else passed++;
      #1 i_p0_VALID = 1'b0;
      @(negedge i_clk);
      i_mem_READY = 1'b0;
      #1;
      checks++; if (o_grant_cnt0 !== 16'd1) $display("FAIL read_idle_ignore_cnt0 got=%h exp=0001", o_grant_cnt0); else passed++;
      $display("txn single_read: p0 addr=00010 rdata=cafef00d");
   endtask

   task automatic test_round_robin();
      logic [5:0] exp_mv, exp_r0, exp_r1;
      logic [ADDR_W-1:0] exp_addr [6];
      exp_mv = 6'b101010;
      exp_r0 = 6'b100010;
      exp_r1 = 6'b001000;
      exp_addr[0] = 18'h0; exp_addr[1] = 18'h00100; exp_addr[2] = 18'h0;
      exp_addr[3] = 18'h00200; exp_addr[4] = 18'h0; exp_addr[5] = 18'h00100;
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1 i_rst_n = 1'b1;
      i_p0_ADDR = 18'h00100; i_p1_ADDR = 18'h00200;
      i_p0_VALID = 1'b1; i_p1_VALID = 1'b1;
      i_mem_READY = 1'b1; i_mem_RDATA = 32'h12345678;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge i_clk);
         #1;
         checks++; if (o_mem_VALID !== exp_mv[i]) $display("FAIL rr_mem_valid[%0d] got=%b exp=%b", i, o_mem_VALID, exp_mv[i]); else passed++;
         checks++; if (o_p0_READY !== exp_r0[i]) $display("FAIL rr_p0_ready[%0d] got=%b exp=%b", i, o_p0_READY, exp_r0[i]); else passed++;
         checks++; if (o_p1_READY !== exp_r1[i]) $display("FAIL rr_p1_ready[%0d] got=%b exp=%b", i, o_p1_READY, exp_r1[i]); else passed++;
         if (exp_mv[i]) begin
            checks++; if (o_mem_ADDR !== exp_addr[i]) $display("FAIL rr_mem_addr[%0d] got=%h exp=%h", i, o_mem_ADDR, exp_addr[i]); else passed++;
            $display("txn round_robin: grant addr=%h", exp_addr[i]);
         end
      end
      @(negedge i_clk);
      i_p0_VALID = 1'b0; i_p1_VALID = 1'b0; i_mem_READY = 1'b0;
      #1;
      checks++; if (o_grant_cnt0 !== 16'd2) $display("FAIL rr_cnt0 got=%h exp=0002", o_grant_cnt0); else passed++;
      checks++; if (o_grant_cnt1 !== 16'd1) $display("FAIL rr_cnt1 got=%h exp=0001", o_grant_cnt1); else passed++;
   endtask

   task automatic test_byte_write();
      @(negedge i_clk);
      i_p0_ADDR = 18'h003FF; i_p0_WDATA = 32'hFFFFFFFF; i_p0_BMASK = 4'hF; i_p0_WREN = 1'b0;
      i_p1_ADDR = 18'h002A0; i_p1_WDATA = 32'h0000AB00; i_p1_BMASK = 4'b0010; i_p1_WREN = 1'b1;
      i_p1_VALID = 1'b1;
      #1;
      checks++; if (o_mem_WDATA !== 32'hFFFFFFFF) $display("FAIL wr_idle_wdata got=%h exp=ffffffff", o_mem_WDATA); else passed++;
      checks++; if (o_mem_BMASK !== 4'hF) $display("FAIL wr_idle_bmask got=%b exp=1111", o_mem_BMASK); else passed++;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL wr_idle_valid got=%b exp=0", o_mem_VALID); else passed++;
      @(negedge i_clk); #1;
      checks++; if (o_mem_BMASK !== 4'b0010) $display("FAIL wr_bmask got=%b exp=0010", o_mem_BMASK); else passed++;
      checks++; if (o_mem_WDATA !== 32'h0000AB00) $display("FAIL wr_wdata got=%h exp=0000ab00", o_mem_WDATA); else passed++;
      checks++; if (o_mem_WREN !== 1'b1) $display("FAIL wr_wren got=%b exp=1", o_mem_WREN); else passed++;
      checks++; if (o_mem_ADDR !== 18'h002A0) $display("FAIL wr_addr got=%h exp=002a0", o_mem_ADDR); else passed++;
      checks++; if (o_mem_VALID !== 1'b1) $display("FAIL wr_valid got=%b exp=1", o_mem_VALID); else passed++;
      @(negedge i_clk);
      i_mem_READY = 1'b1;
      #1;
      checks++; if (o_p1_READY !== 1'b1) $display("FAIL wr_p1_ready got=%b exp=1", o_p1_READY); else passed++;
      checks++; if (o_p0_READY !== 1'b0) $display("FAIL wr_p0_ready got=%b exp=0", o_p0_READY); else passed++;
      @(negedge i_clk);
      i_p1_VALID = 1'b0; i_p1_WREN = 1'b0; i_mem_READY = 1'b0;
      #1;
      checks++; if (o_grant_cnt1 !== 16'd2) $display("FAIL wr_cnt1 got=%h exp=0002", o_grant_cnt1); else passed++;
      $display("txn byte_write: p1 addr=002a0 wdata=0000ab00 bmask=0010");
   endtask

   task automatic test_timeout();
      logic exp_pulse;
      @(negedge i_clk);
      i_p0_ADDR = 18'h00040; i_p0_VALID = 1'b1; i_mem_READY = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge i_clk); #1;
         exp_pulse = (k == 5);
         checks++; if (o_p0_READY !== exp_pulse) $display("FAIL to_p0_ready[%0d] got=%b exp=%b", k, o_p0_READY, exp_pulse); else passed++;
         checks++; if (o_timeout !== exp_pulse) $display("FAIL to_pulse[%0d] got=%b exp=%b", k, o_timeout, exp_pulse); else passed++;
      end
      @(negedge i_clk);
      i_p0_VALID = 1'b0;
      #1;
      checks++; if (o_timeout !== 1'b0) $display("FAIL to_after got=%b exp=0", o_timeout); else passed++;
      checks++; if (o_grant_cnt0 !== 16'd2) $display("FAIL to_cnt0 got=%h exp=0002", o_grant_cnt0); else passed++;
      $display("txn timeout: p0 addr=00040 timed out after 5 busy cycles");
   endtask

   task automatic test_drop_valid();
      @(negedge i_clk);
      i_p1_ADDR = 18'h00055; i_p1_VALID = 1'b1;
      @(negedge i_clk);
      i_p1_VALID = 1'b0; i_mem_READY = 1'b1;
      #1;
      checks++; if (o_p1_READY !== 1'b0) $display("FAIL drop_p1_ready got=%b exp=0", o_p1_READY); else passed++;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL drop_mem_valid got=%b exp=0", o_mem_VALID); else passed++;
      @(negedge i_clk);
      i_p0_ADDR = 18'h00011; i_p1_ADDR = 18'h00022;
      i_p0_VALID = 1'b1; i_p1_VALID = 1'b1; i_mem_READY = 1'b0;
      #1;
      checks++; if (o_grant_cnt1 !== 16'd2) $display("FAIL drop_cnt1 got=%h exp=0002", o_grant_cnt1); else passed++;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL drop_idle got=%b exp=0", o_mem_VALID); else passed++;
      // prio still points at port 1 after the abandoned grant
      @(negedge i_clk); #1;
      checks++; if (o_mem_ADDR !== 18'h00022) $display("FAIL drop_prio_addr got=%h exp=00022", o_mem_ADDR); else passed++;
      @(negedge i_clk);
      i_mem_READY = 1'b1;
      #1;
      checks++; if (o_p1_READY !== 1'b1) $display("FAIL drop_regrant_ready got=%b exp=1", o_p1_READY); else passed++;
      @(negedge i_clk);
      i_p0_VALID = 1'b0; i_p1_VALID = 1'b0; i_mem_READY = 1'b0;
      #1;
      checks++; if (o_grant_cnt1 !== 16'd3) $display("FAIL drop_cnt1_after got=%h exp=0003", o_grant_cnt1); else passed++;
      $display("txn drop_valid: p1 withdrew, then p1 regranted addr=00022");
   endtask

   task automatic test_reset_mid();
      @(negedge i_clk);
      i_p0_ADDR = 18'h00077; i_p0_VALID = 1'b1;
      @(negedge i_clk);
      i_mem_READY = 1'b1;
      @(negedge i_clk);
      i_p0_VALID = 1'b0; i_mem_READY = 1'b0;
      i_p1_ADDR = 18'h00099; i_p1_VALID = 1'b1;
      @(negedge i_clk); #1;
      checks++; if (o_mem_VALID !== 1'b1) $display("FAIL rstmid_busy1 got=%b exp=1", o_mem_VALID); else passed++;
      #2;
      i_mem_READY = 1'b1;
      i_rst_n = 1'b0;
      #1;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL rstmid_mem_valid got=%b exp=0", o_mem_VALID); else passed++;
      checks++; if (o_p1_READY !== 1'b0) $display("FAIL rstmid_p1_ready got=%b exp=0", o_p1_READY); else passed++;
      checks++; if (o_grant_cnt0 !== 16'd0) $display("FAIL rstmid_cnt0 got=%h exp=0000", o_grant_cnt0); else passed++;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_p0_VALID = 1'b1; i_p1_VALID = 1'b1; i_mem_READY = 1'b0;
      #1;
      checks++; if (o_mem_VALID !== 1'b0) $display("FAIL rstmid_idle got=%b exp=0", o_mem_VALID); else passed++;
      @(negedge i_clk); #1;
      checks++; if (o_mem_ADDR !== 18'h00077) $display("FAIL rstmid_prio_addr got=%h exp=00077", o_mem_ADDR); else passed++;
      @(negedge i_clk);
      i_mem_READY = 1'b1;
      #1;
      checks++; if (o_p0_READY !== 1'b1) $display("FAIL rstmid_p0_ready got=%b exp=1", o_p0_READY); else passed++;
      @(negedge i_clk);
      i_p0_VALID = 1'b0; i_p1_VALID = 1'b0; i_mem_READY = 1'b0;
      $display("txn reset_mid: busy1 abandoned, port 0 granted first after release");
   endtask

   task automatic test_saturation();
      logic [15:0] exp_cnt;
      // preload the counter near its ceiling instead of running 65533 real grants
      @(negedge i_clk);
      force dut.grant_cnt1_reg = 16'hFFFD;
      #1 release dut.grant_cnt1_reg;
      #1;
      checks++; if (o_grant_cnt1 !== 16'hFFFD) $display("FAIL sat_preload got=%h exp=fffd", o_grant_cnt1); else passed++;
      for (int j = 0; j < 3; j++) begin
         exp_cnt = (j == 0) ? 16'hFFFE : 16'hFFFF;
         @(negedge i_clk);
         i_p1_ADDR = 18'h00300; i_p1_VALID = 1'b1; i_mem_READY = 1'b1;
         @(negedge i_clk); #1;
         checks++; if (o_p1_READY !== 1'b1) $display("FAIL sat_ready[%0d] got=%b exp=1", j, o_p1_READY); else passed++;
         @(negedge i_clk);
         i_p1_VALID = 1'b0; i_mem_READY = 1'b0;
         #1;
         checks++; if (o_grant_cnt1 !== exp_cnt) $display("FAIL sat_cnt1[%0d] got=%h exp=%h", j, o_grant_cnt1, exp_cnt); else passed++;
         $display("txn saturation: p1 completion %0d cnt1=%h", j, o_grant_cnt1);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_byte_write();
      test_timeout();
      test_drop_valid();
      test_reset_mid();
      test_saturation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 18, memory byte-address width; TIMEOUT, default 255, maximum wait cycles for memory READY per transaction (range 1..65535).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- i_clk  in  1  single clock; all state updates on its rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_p0_ADDR / i_p1_ADDR  in  ADDR_W  requester 0 (CPU LSU) / requester 1 (DMA) byte address
- i_p0_WDATA / i_p1_WDATA  in  32  store data
- i_p0_BMASK / i_p1_BMASK  in  4  byte strobe
- i_p0_WREN / i_p1_WREN  in  1  1 = write, 0 = read
- i_p0_VALID / i_p1_VALID  in  1  request valid
- o_p0_READY / o_p1_READY  out  1  completion pulse
- o_p0_RDATA / o_p1_RDATA  out  32  load data, valid while matching READY is high
- o_mem_ADDR  out  ADDR_W;  o_mem_WDATA  out  32;  o_mem_BMASK  out  4;  o_mem_WREN  out  1;  o_mem_VALID  out  1  downstream data-memory request
- i_mem_RDATA  in  32;  i_mem_READY  in  1  downstream response
- o_timeout  out  1  one-cycle pulse when a transaction times out
- o_grant_cnt0 / o_grant_cnt1  out  16  completed transactions per port, saturating

Function
REQ-003 State machine SHALL have states IDLE, BUSY0, BUSY1.
REQ-004 In IDLE, o_mem_VALID SHALL be 0, and both READY outputs SHALL be 0.
REQ-005 In IDLE with exactly one VALID high, next state SHALL be BUSYn for that port.
REQ-006 In IDLE with both VALIDs high, next state SHALL be BUSYn for the port named by a 1-bit round-robin pointer prio; reset value of prio is 0 (port 0 first).
REQ-007 In BUSYn, o_mem_ADDR/WDATA/BMASK/WREN SHALL be combinationally driven from port n inputs and o_mem_VALID SHALL equal i_pn_VALID.
REQ-008 In IDLE, o_mem_ADDR/WDATA/BMASK/WREN SHALL be driven from port 0 inputs with o_mem_VALID = 0.
REQ-009 In BUSYn, o_pn_READY SHALL equal i_mem_READY. The non-granted port READY SHALL be 0.
REQ-010 o_p0_RDATA and o_p1_RDATA SHALL both equal i_mem_RDATA at all times.
REQ-011 In BUSYn with i_mem_READY = 1:
- next state = IDLE
- prio <= ~n
- grant counter n increments by 1, saturating at 16'hFFFF
REQ-012 Arbitration latency SHALL be exactly one cycle: a request first seen in IDLE reaches o_mem_VALID the following cycle. Back-to-back requests from the same port therefore incur one IDLE cycle between transactions.
REQ-013 A 16-bit wait counter SHALL clear on entry to BUSYn and increment each BUSYn cycle with i_mem_READY = 0.
REQ-014 When the wait counter equals TIMEOUT and i_mem_READY = 0:
- assert o_pn_READY = 1 for that cycle, with RDATA passing through unchanged
- pulse o_timeout = 1
- next state = IDLE, prio <= ~n, grant counter not incremented
REQ-015 If the granted requester drops VALID while in BUSYn (protocol violation): next state SHALL be IDLE, no READY is issued, no counter changes, and prio is unchanged.
REQ-016 i_mem_READY arriving while in IDLE SHALL be ignored.
REQ-017 A newly rising VALID on the non-granted port during BUSYn SHALL be held off (READY = 0) and arbitrated in the next IDLE cycle.

Reset
REQ-018 On i_rst_n = 0, asynchronously and regardless of state:
- state = IDLE, prio = 0, wait counter = 0, grant counters = 0
- o_mem_VALID = 0, o_p0_READY = 0, o_p1_READY = 0, o_timeout = 0
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction with no READY issued. First arbitration after release uses prio = 0.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single read: p0 VALID, ADDR=0x0010, memory READY one cycle after o_mem_VALID with RDATA=0xCAFEF00D -> o_p0_READY pulse with o_p0_RDATA=0xCAFEF00D; o_grant_cnt0=1; state IDLE.
- Simultaneous after reset: both VALID, memory always READY -> p0 served first, then p1, then p0; prio toggles each grant; o_p1_READY never high in BUSY0.
- Byte write pass-through: p1 WREN=1, BMASK=4'b0010, WDATA=0x0000AB00 in BUSY1 -> o_mem_BMASK=4'b0010, o_mem_WDATA=0x0000AB00, o_mem_WREN=1.
- Timeout: TIMEOUT=4, memory never READY -> o_p0_READY and o_timeout pulse together on the 5th BUSY0 cycle; o_grant_cnt0 unchanged.
- Reset mid-BUSY1: assert i_rst_n=0 between clock edges -> o_mem_VALID=0 immediately; after release, both VALID -> port 0 granted.
- Saturation: force 65536 p1 completions -> o_grant_cnt1 holds 16'hFFFF.
